// File: rtl/bpio_sequencer.sv
// SPI command sequencer: pulls 16-bit command words from a show-ahead FIFO and runs SPI transfers, CS updates, delays and marks.
// Latency: 3 clocks per single-word non-shift command; a transfer shifts for 2*nbits*(clkdiv+1) clocks and then pushes its result.
// Backpressure: waits in GETDATA until a data word is available and in PUSH while res_full is high; results are never dropped.
module bpio_sequencer #(
  parameter int FIFO_WIDTH   = 16,
  parameter int CS_COUNT     = 2,
  parameter int CLKDIV_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [FIFO_WIDTH-1:0]   cmd_data,
  input  logic                    cmd_nempty,
  output logic                    cmd_pop,
  output logic [FIFO_WIDTH-1:0]   res_data,
  output logic                    res_push,
  input  logic                    res_full,
  input  logic                    cfg_cpol,
  input  logic                    cfg_cpha,
  input  logic [CLKDIV_WIDTH-1:0] cfg_clkdiv,
  output logic                    spi_sclk,
  output logic                    spi_mosi,
  input  logic                    spi_miso,
  output logic [CS_COUNT-1:0]     spi_cs,
  output logic                    busy,
  output logic                    err_opcode
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_GETDATA, ST_SHIFT, ST_PUSH, ST_DELAY
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_XFER8 = 4'h1;
  localparam logic [3:0] OP_XFERW = 4'h2;
  localparam logic [3:0] OP_CS    = 4'h3;
  localparam logic [3:0] OP_DELAY = 4'h4;
  localparam logic [3:0] OP_MARK  = 4'h5;
  localparam logic [CLKDIV_WIDTH-1:0] DIV_ONE = 1;

  state_t                  state_q;
  logic [FIFO_WIDTH-1:0]   cmd_q;
  logic [FIFO_WIDTH-1:0]   sh_q;
  logic [FIFO_WIDTH-1:0]   res_q;
  logic [4:0]              nbits_q;
  logic [5:0]              edge_q;
  logic [CLKDIV_WIDTH-1:0] div_q;
  logic [CLKDIV_WIDTH-1:0] clkdiv_q;
  logic                    cpha_q;
  logic [11:0]             dly_q;
  logic                    sclk_q;
  logic                    mosi_q;
  logic [CS_COUNT-1:0]     cs_q;
  logic                    err_q;

  logic [3:0]            opcode;
  logic [11:0]           arg;
  logic                  edge_now;
  logic                  last_edge;
  logic                  odd_edge;
  logic                  do_sample;
  logic                  do_update;
  logic                  start_shift;
  logic [FIFO_WIDTH-1:0] sh_smp;
  logic [FIFO_WIDTH-1:0] ld_w;

  assign opcode = cmd_q[15:12];
  assign arg    = cmd_q[11:0];

  // Edge scheduling for SHIFT, plus the left-aligned TX word loaded on SHIFT entry.
  always_comb begin
    edge_now    = (state_q == ST_SHIFT) && (div_q == clkdiv_q);
    last_edge   = (edge_q == ({nbits_q, 1'b0} - 6'd1));
    // edge_q counts completed edges, so the edge happening now is odd when edge_q is even
    odd_edge    = ~edge_q[0];
    do_sample   = edge_now && (odd_edge != cpha_q);
    // the closing edge never moves mosi, so it holds the last transmitted bit
    do_update   = edge_now && (odd_edge == cpha_q) && !last_edge;
    sh_smp      = {sh_q[FIFO_WIDTH-2:0], spi_miso};
    start_shift = ((state_q == ST_DECODE) && (opcode == OP_XFER8)) ||
                  ((state_q == ST_GETDATA) && cmd_nempty);
    // left-aligning the TX bits means rx ends up right-aligned with zero upper bits
    if (state_q == ST_DECODE) ld_w = {arg[7:0], 8'h00};
    else                      ld_w = cmd_data << (5'd16 - nbits_q);
  end

  // Main sequencer: state, datapath registers and registered SPI outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      sh_q     <= '0;
      res_q    <= '0;
      nbits_q  <= '0;
      edge_q   <= '0;
      div_q    <= '0;
      clkdiv_q <= '0;
      cpha_q   <= 1'b0;
      dly_q    <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_q     <= '1;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sclk_q <= cfg_cpol;
          if (cmd_nempty) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          cmd_q   <= cmd_data;
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          case (opcode)
            OP_NOP:   state_q <= ST_IDLE;
            OP_XFER8: nbits_q <= 5'd8;
            OP_XFERW: begin
              nbits_q <= {1'b0, arg[3:0]} + 5'd1;
              state_q <= ST_GETDATA;
            end
            OP_CS: begin
              for (int i = 0; i < CS_COUNT; i++) begin
                if (arg[i]) cs_q[i] <= arg[8];
              end
              state_q <= ST_IDLE;
            end
            OP_DELAY: begin
              dly_q   <= '0;
              state_q <= ST_DELAY;
            end
            OP_MARK: begin
              res_q   <= {4'hF, arg};
              state_q <= ST_PUSH;
            end
            default: begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          endcase
        end
        ST_GETDATA: begin
          // SHIFT entry for the data word is handled by start_shift below
        end
        ST_SHIFT: begin
          if (edge_now) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            edge_q <= edge_q + 6'd1;
            if (do_sample) sh_q <= sh_smp;
            if (do_update) mosi_q <= sh_q[FIFO_WIDTH-1];
            if (last_edge) begin
              res_q   <= do_sample ? sh_smp : sh_q;
              state_q <= ST_PUSH;
            end
          end else begin
            div_q <= div_q + DIV_ONE;
          end
        end
        ST_PUSH: begin
          if (!res_full) state_q <= ST_IDLE;
        end
        ST_DELAY: begin
          if (dly_q == arg) state_q <= ST_IDLE;
          else              dly_q   <= dly_q + 12'd1;
        end
        default: state_q <= ST_IDLE;
      endcase

      // Transfer start: snapshot the SPI config so mid-transfer changes are ignored.
      if (start_shift) begin
        sh_q     <= ld_w;
        mosi_q   <= ld_w[FIFO_WIDTH-1];
        sclk_q   <= cfg_cpol;
        cpha_q   <= cfg_cpha;
        clkdiv_q <= cfg_clkdiv;
        div_q    <= '0;
        edge_q   <= '0;
        state_q  <= ST_SHIFT;
      end
    end
  end

  assign cmd_pop    = (state_q == ST_FETCH) || ((state_q == ST_GETDATA) && cmd_nempty);
  assign res_push   = (state_q == ST_PUSH) && !res_full;
  assign res_data   = res_q;
  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_q;
  assign spi_cs     = cs_q;
  assign busy       = (state_q != ST_IDLE);
  assign err_opcode = err_q;

endmodule

// File: tb/tb_bpio_sequencer.sv
// Bench for bpio_sequencer: command FIFO model, result scoreboard, table of SPI transfers plus hand sequences.
// Latency: observes outputs on the falling edge, pops the FIFO model just after the rising edge.
// Backpressure: drives res_full to hold results and checks no push happens while full.
module tb_bpio_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] cmd_data;
  logic        cmd_nempty;
  logic        cmd_pop;
  logic [15:0] res_data;
  logic        res_push;
  logic        res_full;
  logic        cfg_cpol;
  logic        cfg_cpha;
  logic [7:0]  cfg_clkdiv;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic [1:0]  spi_cs;
  logic        busy;
  logic        err_opcode;

  logic        loop_en;
  logic        miso_fix;

  assign spi_miso = loop_en ? spi_mosi : miso_fix;

  always #5 clock = ~clock;

  bpio_sequencer #(.FIFO_WIDTH(16), .CS_COUNT(2), .CLKDIV_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .cmd_data(cmd_data), .cmd_nempty(cmd_nempty), .cmd_pop(cmd_pop),
    .res_data(res_data), .res_push(res_push), .res_full(res_full),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_clkdiv(cfg_clkdiv),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_cs(spi_cs), .busy(busy), .err_opcode(err_opcode)
  );

  int errs   = 0;
  int checks = 0;

  logic [15:0] fifo[$];
  logic [15:0] exp_q[$];
  int          runs[$];
  int          pop_cycs[$];

  int          cyc = 0;
  int          push_count = 0;
  int          pop_count = 0;
  int          push_cyc = 0;
  int          last_pop_cyc = 0;
  int          busy_run = 0;
  int          bit_cnt = 0;
  logic [15:0] tx_bits = 16'h0;
  logic [1:0]  cs_at_push = 2'b11;
  logic        prev_sclk = 1'b0;

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] data;
    logic        two;
    logic        cpol;
    logic        cpha;
    logic [7:0]  div;
    logic        loopb;
    logic        miso_v;
    logic [15:0] exp_res;
    int          exp_shift;
    logic [15:0] exp_tx;
    int          exp_n;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic refresh();
    cmd_nempty = (fifo.size() != 0);
    cmd_data   = (fifo.size() != 0) ? fifo[0] : 16'h0;
  endtask

  task automatic cmd_push(input logic [15:0] w);
    fifo.push_back(w);
    refresh();
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic wait_push(input int target, input string nm);
    int n = 0;
    while (push_count < target && n < 3000) begin
      @(negedge clock); #1;
      n++;
    end
    if (push_count < target) begin
      errs++; checks++;
      $display("FAIL %s: timeout, pushes %0d expected %0d", nm, push_count, target);
    end
  endtask

  // Falling-edge monitor + scoreboard; the FIFO model pops just after the rising edge that consumed the word.
  initial begin
    logic        pend;
    logic [15:0] expv;
    logic [15:0] tmp;
    forever begin
      @(negedge clock);
      cyc++;
      if (res_full) chk("no_push_while_full", {31'b0, res_push}, 32'd0);
      if (res_push) begin
        push_count++;
        push_cyc   = cyc;
        cs_at_push = spi_cs;
        if (exp_q.size() == 0) begin
          errs++; checks++;
          $display("FAIL unexpected_push: got %h, nothing expected", res_data);
        end else begin
          expv = exp_q.pop_front();
          chk("result", {16'b0, res_data}, {16'b0, expv});
        end
      end
      if (cmd_pop) begin
        pop_count++;
        last_pop_cyc = cyc;
        pop_cycs.push_back(cyc);
      end
      if (busy) begin
        if (spi_sclk != prev_sclk && ((spi_sclk != cfg_cpol) != cfg_cpha)) begin
          bit_cnt++;
          tx_bits = {tx_bits[14:0], spi_mosi};
        end
        busy_run++;
      end else if (busy_run > 0) begin
        runs.push_back(busy_run);
        busy_run = 0;
      end
      prev_sclk = spi_sclk;
      pend = cmd_pop;
      @(posedge clock); #1;
      if (pend && fifo.size() > 0) begin
        tmp = fifo.pop_front();
        refresh();
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    int shift;
    vecs[0] = '{16'h11A5, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 16'h00A5, 16, 16'h00A5, 8};
    vecs[1] = '{16'h113C, 16'h0000, 1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 16'h003C, 64, 16'h003C, 8};
    vecs[2] = '{16'h11FF, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 16'h0000, 32, 16'h00FF, 8};
    vecs[3] = '{16'h200B, 16'hABCD, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 16'h0FFF, 24, 16'h0BCD, 12};
    vecs[4] = '{16'h200F, 16'h8001, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 16'h8001, 32, 16'h8001, 16};
    vecs[5] = '{16'h2000, 16'hFFFF, 1'b1, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 16'h0001, 6,  16'h0001, 1};
    vecs[6] = '{16'h2007, 16'h12C3, 1'b1, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 16'h00C3, 16, 16'h00C3, 8};

    reset = 1'b0; res_full = 1'b0;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_clkdiv = 8'd0;
    loop_en = 1'b0; miso_fix = 1'b0;
    refresh();
    cmd_push(16'h0000);
    cyc_wait(2);

    // Reset values with a command already waiting.
    chk("rst_cmd_pop",  {31'b0, cmd_pop}, 0);
    chk("rst_res_push", {31'b0, res_push}, 0);
    chk("rst_res_data", {16'b0, res_data}, 0);
    chk("rst_sclk",     {31'b0, spi_sclk}, 0);
    chk("rst_mosi",     {31'b0, spi_mosi}, 0);
    chk("rst_cs",       {30'b0, spi_cs}, 32'h3);
    chk("rst_busy",     {31'b0, busy}, 0);
    chk("rst_err",      {31'b0, err_opcode}, 0);

    @(negedge clock); reset = 1'b1;
    #1 chk("no_pop_before_edge1", {31'b0, cmd_pop}, 0);
    cyc_wait(4);
    chk("first_nop_consumed", fifo.size(), 0);

    // Back-to-back NOPs: one pop every 3 clocks.
    pop_cycs.delete();
    cmd_push(16'h0000); cmd_push(16'h0000); cmd_push(16'h0000);
    cyc_wait(14);
    chk("nop_pops", pop_cycs.size(), 3);
    if (pop_cycs.size() == 3) begin
      chk("nop_spacing_a", pop_cycs[1] - pop_cycs[0], 3);
      chk("nop_spacing_b", pop_cycs[2] - pop_cycs[1], 3);
    end

    cmd_push(16'h3001);
    cyc_wait(5);
    chk("cs0_low", {30'b0, spi_cs}, 32'h2);

    // Table of transfers.
    for (int i = 0; i < 7; i++) begin
      cfg_cpol = vecs[i].cpol; cfg_cpha = vecs[i].cpha; cfg_clkdiv = vecs[i].div;
      loop_en = vecs[i].loopb; miso_fix = vecs[i].miso_v;
      cyc_wait(2);
      bit_cnt = 0; tx_bits = 16'h0;
      pc = push_count;
      exp_q.push_back(vecs[i].exp_res);
      cmd_push(vecs[i].cmd);
      if (vecs[i].two) cmd_push(vecs[i].data);
      wait_push(pc + 1, "xfer_push");
      shift = push_cyc - last_pop_cyc - (vecs[i].two ? 1 : 2);
      chk("shift_clocks", shift, vecs[i].exp_shift);
      chk("cs_during_xfer", {30'b0, cs_at_push}, 32'h2);
      cyc_wait(2);
      chk("sclk_idle", {31'b0, spi_sclk}, {31'b0, vecs[i].cpol});
      chk("mosi_bits", bit_cnt, vecs[i].exp_n);
      chk("mosi_seq", {16'b0, tx_bits}, {16'b0, vecs[i].exp_tx});
    end

    cmd_push(16'h3101); cyc_wait(5);
    chk("cs0_high", {30'b0, spi_cs}, 32'h3);
    cmd_push(16'h3006); cyc_wait(5);
    chk("cs1_low_only", {30'b0, spi_cs}, 32'h1);
    cmd_push(16'h3103); cyc_wait(5);
    chk("cs_all_high", {30'b0, spi_cs}, 32'h3);

    // Backpressure on a MARK.
    res_full = 1'b1;
    pc = push_count;
    exp_q.push_back(16'hF123);
    cmd_push(16'h5123);
    cyc_wait(10);
    chk("bp_held", push_count, pc);
    res_full = 1'b0;
    @(negedge clock); #1;
    chk("bp_first_free", push_count, pc + 1);
    cyc_wait(5);
    chk("bp_once", push_count, pc + 1);

    // Undefined opcode, then a normal command.
    pc = push_count;
    cmd_push(16'hE123);
    exp_q.push_back(16'hF456);
    cmd_push(16'h5456);
    wait_push(pc + 1, "after_err_push");
    chk("err_set", {31'b0, err_opcode}, 1);
    chk("err_word_consumed", fifo.size(), 0);

    // Delay timing with cpol=1.
    cfg_cpol = 1'b1; cfg_cpha = 1'b1; cfg_clkdiv = 8'd3;
    cyc_wait(3);
    chk("sclk_idle_high", {31'b0, spi_sclk}, 1);
    runs.delete();
    pc = push_count;
    cmd_push(16'h4009);
    exp_q.push_back(16'hF001);
    cmd_push(16'h5001);
    wait_push(pc + 1, "delay_mark_push");
    if (runs.size() > 0) chk("delay_busy_run", runs[0], 12);
    else begin errs++; checks++; $display("FAIL delay_busy_run: got none expected 12"); end

    cyc_wait(3);
    runs.delete();
    cmd_push(16'h4FFF);
    for (int n = 0; n < 6000 && runs.size() == 0; n++) @(negedge clock);
    #1;
    if (runs.size() > 0) chk("delay_max_run", runs[0], 4098);
    else begin errs++; checks++; $display("FAIL delay_max_run: timeout, expected 4098"); end

    // Reset in the middle of a transfer.
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_clkdiv = 8'd0;
    loop_en = 1'b0; miso_fix = 1'b1;
    cyc_wait(2);
    pc = pop_count;
    cmd_push(16'h3003);
    cmd_push(16'h11FF);
    for (int n = 0; n < 100 && pop_count < pc + 2; n++) begin
      @(negedge clock); #1;
    end
    chk("xfer_fetched", pop_count, pc + 2);
    repeat (6) @(posedge clock);
    #2;
    chk("cs_low_in_shift", {30'b0, spi_cs}, 0);
    chk("busy_in_shift", {31'b0, busy}, 1);
    pc = push_count;
    reset = 1'b0;
    #1;
    chk("abort_cs", {30'b0, spi_cs}, 32'h3);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_err", {31'b0, err_opcode}, 0);
    chk("abort_push", {31'b0, res_push}, 0);
    chk("abort_sclk", {31'b0, spi_sclk}, 0);
    cyc_wait(3);
    reset = 1'b1;
    cyc_wait(10);
    chk("abort_no_result", push_count, pc);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
